// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-forwarding and load-use hazard controller for a MIPS32
// five-stage pipeline. It tracks the destination of the instructions in
// EX/MEM/WB and drives the registered 2-bit selects of the ALU operand muxes.
// It also raises a combinational stall when a load is followed by a consumer
// of the loaded register.
//
// Ports:
//   clk, rst            pipeline clock, asynchronous active-high reset
//   id_valid            ID instruction valid and advancing
//   id_rs/id_rt         source registers, qualified by id_use_rs/id_use_rt
//   id_dst/id_regwrite  destination register and its write enable
//   id_memread          ID instruction is a load
//   flush               discard the ID instruction (branch redirect)
//   sel_a/sel_b         operand mux selects (registered)
//                       00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass
//   stall               hold PC and IF/ID, bubble into EX (combinational)
//   stall_cnt           saturating count of stall cycles

// Per-operand match and priority logic. Stage index 0=EX, 1=MEM, 2=WB.
module fwd_ctrl_sel #(
    parameter int REG_BITS = 5
) (
    input  logic [REG_BITS-1:0]      src,
    input  logic                     use_src,
    input  logic [2:0][REG_BITS-1:0] dst,
    input  logic [2:0]               wr,
    output logic                     ex_hit,
    output logic [1:0]               sel
);
    logic [2:0] hit;

    always_comb begin
        for (int k = 0; k < 3; k++)
            hit[k] = use_src && wr[k] && (dst[k] != '0) && (dst[k] == src);
        // Youngest producer wins.
        sel = 2'b00;
        if (hit[0])      sel = 2'b01;
        else if (hit[1]) sel = 2'b10;
        else if (hit[2]) sel = 2'b11;
    end

    assign ex_hit = hit[0];
endmodule

module fwd_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [REG_BITS-1:0] id_dst,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                flush,
    output logic [1:0]          sel_a,
    output logic [1:0]          sel_b,
    output logic                stall,
    output logic [CNT_BITS-1:0] stall_cnt
);
    // Tracking state: [0]=EX, [1]=MEM, [2]=WB. Only EX needs the load flag.
    logic [2:0][REG_BITS-1:0] st_dst;
    logic [2:0]               st_wr;
    logic                     ex_ld;

    // Operand 0 = A (rs), operand 1 = B (rt).
    logic [1:0][REG_BITS-1:0] op_src;
    logic [1:0]               op_use;
    logic [1:0][1:0]          sel_nxt;
    logic [1:0][1:0]          sel_q;
    logic [1:0]               ex_hit;
    logic                     advance;

    assign op_src = {id_rt, id_rs};
    assign op_use = {id_use_rt, id_use_rs};

    for (genvar i = 0; i < 2; i++) begin : g_op
        fwd_ctrl_sel #(.REG_BITS(REG_BITS)) u_sel (
            .src    (op_src[i]),
            .use_src(op_use[i]),
            .dst    (st_dst),
            .wr     (st_wr),
            .ex_hit (ex_hit[i]),
            .sel    (sel_nxt[i])
        );
    end

    // A load in EX cannot forward yet: its data appears only after MEM.
    assign stall   = id_valid && !flush && ex_ld && st_wr[0] &&
                     (st_dst[0] != '0) && (|ex_hit);
    assign advance = id_valid && !stall && !flush;

    assign sel_a = sel_q[0];
    assign sel_b = sel_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_dst    <= '0;
            st_wr     <= '0;
            ex_ld     <= 1'b0;
            sel_q     <= '0;
            stall_cnt <= '0;
        end else begin
            st_dst[2] <= st_dst[1];
            st_wr[2]  <= st_wr[1];
            st_dst[1] <= st_dst[0];
            st_wr[1]  <= st_wr[0];
            if (advance) begin
                st_dst[0] <= id_dst;
                st_wr[0]  <= id_regwrite && (id_dst != '0);
                ex_ld     <= id_memread;
                sel_q     <= sel_nxt;
            end else begin
                st_dst[0] <= '0;
                st_wr[0]  <= 1'b0;
                ex_ld     <= 1'b0;
                sel_q     <= '0;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fwd_ctrl.sv
module tb_fwd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [1:0] sel_a, sel_b, sel_a2, sel_b2;
    logic       stall, stall2;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_ctrl #(.REG_BITS(5), .CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance on the same inputs, for saturation.
    fwd_ctrl #(.REG_BITS(5), .CNT_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .sel_a(sel_a2), .sel_b(sel_b2), .stall(stall2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] = what entered EX k+1 edges ago; age 1..3 maps onto select 1..3.
    typedef struct { int dst; bit wr; bit ld; } ent_t;
    ent_t hist[3];
    int   m_sel_a, m_sel_b, m_cnt, m_cnt2;

    function automatic bit mt(int k, int s, bit u);
        return u && hist[k].wr && hist[k].dst != 0 && hist[k].dst == s;
    endfunction

    function automatic int m_sel(int s, bit u);
        for (int k = 0; k < 3; k++) if (mt(k, s, u)) return k + 1;
        return 0;
    endfunction

    function automatic bit m_stall();
        return id_valid && !flush && hist[0].ld && hist[0].wr &&
               (mt(0, id_rs, id_use_rs) || mt(0, id_rt, id_use_rt));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
            m_sel_a = 0; m_sel_b = 0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            bit st, adv;
            st  = m_stall();
            adv = id_valid && !st && !flush;
            m_sel_a = adv ? m_sel(id_rs, id_use_rs) : 0;
            m_sel_b = adv ? m_sel(id_rt, id_use_rt) : 0;
            if (st && m_cnt < 65535) m_cnt++;
            if (st && m_cnt2 < 3) m_cnt2++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (adv) hist[0] = '{int'(id_dst), id_regwrite && id_dst != 0, id_memread};
            else     hist[0] = '{0, 0, 0};
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_sel_a", sel_a, m_sel_a);
            chk("m_sel_b", sel_b, m_sel_b);
            chk("m_stall", stall, m_stall());
            chk("m_cnt", stall_cnt, m_cnt);
            chk("m_cnt2", stall_cnt2, m_cnt2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dst, input bit rw, input bit mr, input bit fl);
        id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_use_rs = urs; id_use_rt = urt;
        id_dst = dst[4:0]; id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc();
    endtask

    initial begin
        int gap_exp[5];
        gap_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_sel_a", sel_a, 0);
        chk("rst_sel_b", sel_b, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", stall_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // ALU dependency at distance 1..4
        for (int gap = 1; gap <= 4; gap++) begin
            drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
            cyc();
            nops(gap - 1);
            drv(1, 3, 4, 1, 1, 0, 0, 0, 0);
            cyc();
            chk($sformatf("dist%0d_sel_a", gap), sel_a, gap_exp[gap]);
            chk($sformatf("dist%0d_sel_b", gap), sel_b, 0);
            nops(3);
        end

        // Load-use: one stall, then MEM/WB forward
        drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
        cyc();
        drv(1, 0, 7, 0, 1, 0, 0, 0, 0);
        #1;
        chk("lu_stall_hi", stall, 1);
        chk("lu_cnt0", stall_cnt, 0);
        cyc();
        chk("lu_stall_lo", stall, 0);
        chk("lu_cnt1", stall_cnt, 1);
        chk("lu_bubble_sel", sel_b, 0);
        cyc();
        chk("lu_sel_b", sel_b, 2);
        nops(3);

        // Priority: three writers of r2
        repeat (3) begin
            drv(1, 0, 0, 0, 0, 2, 1, 0, 0);
            cyc();
        end
        drv(1, 2, 0, 1, 0, 0, 0, 0, 0);
        cyc();
        chk("prio_sel_a", sel_a, 1);
        nops(3);

        // $0 never forwarded
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc();
        drv(1, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc();
        chk("r0_sel_a", sel_a, 0);
        nops(3);

        // Unused operand: no forward, no stall even behind a load
        drv(1, 0, 0, 0, 0, 9, 1, 1, 0);
        cyc();
        drv(1, 0, 9, 0, 0, 0, 0, 0, 0);
        #1;
        chk("nouse_stall", stall, 0);
        cyc();
        chk("nouse_sel_b", sel_b, 0);
        nops(3);

        // Flush beats stall
        drv(1, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc();
        drv(1, 1, 0, 1, 0, 0, 0, 0, 1);
        #1;
        chk("flush_stall", stall, 0);
        cyc();
        chk("flush_sel_a", sel_a, 0);
        chk("flush_cnt", stall_cnt, 1);
        nops(3);

        // Four more load-use hazards: total 5, narrow counter saturates
        repeat (4) begin
            drv(1, 0, 0, 0, 0, 7, 1, 1, 0);
            cyc();
            drv(1, 0, 7, 0, 1, 0, 0, 0, 0);
            cyc();
            cyc();
            nops(1);
        end
        chk("sat_cnt16", stall_cnt, 5);
        chk("sat_cnt2", stall_cnt2, 3);
        nops(2);

        // Asynchronous reset mid-stream
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0);
        cyc();
        drv(1, 5, 0, 1, 0, 5, 1, 0, 0);
        cyc();
        chk("pre_rst_sel_a", sel_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel_a", sel_a, 0);
        chk("arst_sel_b", sel_b, 0);
        chk("arst_stall", stall, 0);
        chk("arst_cnt", stall_cnt, 0);
        chk("arst_cnt2", stall_cnt2, 0);
        #2 rst = 1'b0;
        drv(1, 5, 0, 1, 0, 0, 0, 0, 0);
        cyc();
        chk("post_rst_sel_a", sel_a, 0);
        nops(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
